// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: packs variable-length codewords MSB-first into bytes.
// Flush drains the final partial byte zero-padded and tagged out_last.
module huffman_bit_packer #(
    parameter int OUT_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      code,
    input  logic [4:0]       code_len,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             flush_done
);

    localparam int CW = $clog2(ACC_W + 1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_p;
    logic [ACC_W-1:0] acc_n;
    logic [ACC_W-1:0] ins;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_p;
    logic [CW-1:0]    cnt_n;
    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [4:0]       len;
    logic [15:0]      mask;
    logic [15:0]      bits;
    logic             pop;
    logic             take;

    assign in_ready   = (state == S_RUN) && !flush && (cnt <= CW'(16));
    assign out_valid  = (cnt >= CW'(OUT_W)) ||
                        ((state == S_FLUSH) && (cnt != '0));
    assign out_data   = acc[ACC_W-1 -: OUT_W];
    assign out_last   = (state == S_FLUSH) && (cnt != '0) &&
                        (cnt < CW'(OUT_W));
    assign flush_done = (state == S_DONE);

    assign pop  = out_valid && out_ready;
    assign take = in_valid && in_ready;

    assign len  = (code_len > 5'd16) ? 5'd16 : code_len;
    assign mask = 16'((17'h1 << len) - 17'h1);
    assign bits = code & mask;

    // Left-align the codeword, then drop it just below the surviving bits.
    assign ins = (ACC_W'(bits) << (ACC_W - int'(len))) >> cnt_p;

    always_comb begin
        acc_p = acc;
        cnt_p = cnt;
        if (pop) begin
            acc_p = acc << OUT_W;
            cnt_p = (cnt >= CW'(OUT_W)) ? cnt - CW'(OUT_W) : '0;
        end
        acc_n = acc_p;
        cnt_n = cnt_p;
        if (take) begin
            acc_n = acc_p | ins;
            cnt_n = cnt_p + CW'(len);
        end
    end

    always_comb begin
        state_n = state;
        unique case (1'b1)
            state == S_RUN:   if (flush) state_n = S_FLUSH;
            state == S_FLUSH: if (cnt_p == '0) state_n = S_DONE;
            state == S_DONE:  state_n = S_RUN;
            default:          state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
        end else begin
            acc   <= acc_n;
            cnt   <= cnt_n;
            state <= state_n;
        end
    end

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Downstream stage of the Huffman encoder. It accepts variable-length codewords (up to 16 bits, each with a bit length) and packs them MSB-first into a continuous byte stream. A 32-bit bit accumulator with valid/ready handshakes on both sides absorbs the rate mismatch. A flush request drains the final partial byte, zero-padded, and marks it as the last byte of the stream.

## Interface
Parameters:
- OUT_W, 8: output byte width; fixed, not to be overridden.
- ACC_W, 32: accumulator width in bits; must be ≥ 16 + OUT_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- in_valid  in  1  codeword present on code/code_len.
- in_ready  out  1  packer can accept a codeword this cycle.
- code  in  16  codeword, right-aligned. Only bits [code_len-1:0] are used; higher bits are masked.
- code_len  in  5  codeword length. 0 = accepted, no bits added. 1..16 = valid lengths. 17..31 = treated as 16.
- flush  in  1  level-sampled drain request, honoured only in RUN.
- out_valid  out  1  out_data holds a byte.
- out_ready  in  1  consumer accepts the byte.
- out_data  out  8  packed byte; first stream bit is bit 7.
- out_last  out  1  qualifies out_data as the final, padded byte of a flush.
- flush_done  out  1  one-cycle pulse when a flush has completed.

## Operation
- State: acc[31:0], left-aligned (the oldest bit is acc[31]); cnt[5:0] = valid bits, range 0..32; FSM {RUN, FLUSH, DONE}.
- Reset values: acc=0, cnt=0, state=RUN, out_valid=0, out_last=0, flush_done=0. in_ready=1 after reset is released.
- in_ready = (state==RUN) && !flush && (cnt ≤ 16). It is combinational from registered state plus flush; there is no path from in_valid.
- Accept: in_valid && in_ready.
  - Masked code is OR-ed into acc at bit offset (32 − cnt' − len).
  - cnt' = cnt after any same-cycle byte pop.
  - cnt ← cnt' + len.
- out_data = acc[31:24].
- out_valid = (cnt ≥ 8) || (state==FLUSH && cnt > 0). Both outputs are driven from registers only.
- Pop: out_valid && out_ready → acc ← acc << 8 (zero fill), cnt ← cnt − 8 (saturating at 0 for the partial byte).
- A pop and an accept in the same cycle are both performed; the shift is applied before the new code is inserted.
- RUN → FLUSH when flush=1. No code is accepted in that cycle.
- FLUSH: full bytes pop normally. When 0 < cnt < 8, out_data = acc[31:24] with the unused low bits already 0, and out_last=1. The pop takes cnt→0 and acc→0.
- FLUSH → DONE when cnt==0 (including entry with cnt==0, in which case no byte is emitted). DONE: flush_done=1 for one cycle, then → RUN.
- out_last is 1 only on the padded byte. A flush that ends on a byte boundary emits no out_last byte.
- While out_valid=1 && out_ready=0, out_data/out_last stay stable. cnt cannot exceed 32 because in_ready requires cnt ≤ 16.
- Asynchronous reset at any point discards the accumulator contents and any pending flush. No partial output is emitted afterwards.

## Timing
- A code accepted at edge k is visible as out_valid=1 after edge k, if cnt ≥ 8 then. Input-to-output latency is 1 cycle.
- Sustained throughput: one byte per cycle out. Input stalls only when cnt > 16.
- Flush entry: FLUSH after the edge that samples flush. Each remaining byte takes one cycle with out_ready=1. DONE lasts 1 cycle, and RUN/in_ready return the following cycle.
- A flush with empty acc takes 2 cycles (FLUSH, DONE) and produces no output.

## Test plan
- Reset: assert rst_n=0 mid-stream with cnt=13 → all outputs immediately 0 (out_valid=0, flush_done=0). After release: in_ready=1, cnt=0. No stale byte is ever emitted.
- Basic packing: code=3'b101/len 3, then 5'b11110/len 5, out_ready=1 → a single byte 0xBE, out_last=0, one cycle after the second accept.
- Masking/len rules: code=16'hFFFF/len 2, code=16'hFFFF/len 0, code=16'h0000/len 6 → 0xC0. A len-0 code leaves cnt unchanged.
- Backpressure: out_ready=0; push 16'hFFFF/16 and 16'h00FF/16 → cnt=32, in_ready=0, a third code is held. Raise out_ready → bytes FF FF 00 FF in order, third code then accepted.
- Flush partial: code=4'hA/len 4, then flush=1 → byte 0xA0 with out_last=1, then flush_done pulse for exactly one cycle, then in_ready=1. A flush with empty acc gives no byte, only a flush_done pulse.
- Simultaneous pop/accept: cnt=12, out_ready=1, push 8'h5A/len 8 → the pop and the insert happen in the same edge, giving cnt=12 and correct bit order across three successive bytes.
